// File: rtl/vo_match_pkg.sv
// Shared widths and FSM encoding for the visual-odometry descriptor matcher.
package vo_match_pkg;
  localparam int DESC_W = 256;
  localparam int DIST_W = 9;
  localparam logic [DIST_W-1:0] DIST_MAX = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } match_state_e;
endpackage

// File: rtl/desc_matcher_if.sv
// Store/query/distance-unit/result signal bundle of desc_matcher.
interface desc_matcher_if #(parameter int DEPTH = 64);
  import vo_match_pkg::*;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic              i_dst_wr;
  logic [DESC_W-1:0] i_dst_desc;
  logic              i_dst_clear;
  logic              o_dst_ready;
  logic [CW-1:0]     o_dst_count;
  logic              i_query_valid;
  logic [DESC_W-1:0] i_query_desc;
  logic              o_query_ready;
  logic              o_ham_valid;
  logic [DESC_W-1:0] o_src_desc;
  logic [DESC_W-1:0] o_dst_desc;
  logic [DIST_W-1:0] i_ham_dist;
  logic              i_ham_valid;
  logic              o_match_valid;
  logic              o_match_found;
  logic [IW-1:0]     o_match_idx;
  logic [DIST_W-1:0] o_match_dist;

  modport slave (
    input  i_dst_wr, i_dst_desc, i_dst_clear, i_query_valid, i_query_desc,
           i_ham_dist, i_ham_valid,
    output o_dst_ready, o_dst_count, o_query_ready, o_ham_valid, o_src_desc,
           o_dst_desc, o_match_valid, o_match_found, o_match_idx, o_match_dist
  );

  modport master (
    output i_dst_wr, i_dst_desc, i_dst_clear, i_query_valid, i_query_desc,
           i_ham_dist, i_ham_valid,
    input  o_dst_ready, o_dst_count, o_query_ready, o_ham_valid, o_src_desc,
           o_dst_desc, o_match_valid, o_match_found, o_match_idx, o_match_dist
  );
endinterface

// File: rtl/desc_buffer.sv
// DEPTH x DESC_W reference descriptor store: synchronous write, combinational read.
module desc_buffer
  import vo_match_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DESC_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DESC_W-1:0] rdata
);
  logic [DEPTH-1:0][DESC_W-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/desc_matcher.sv
// Brute-force best-match search over stored descriptors via an external Hamming unit.
// Optional MATCH_RATIO_TEST_EN adds second-best tracking and the 4*best < 3*second test.
module desc_matcher
  import vo_match_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int DIST_TH = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  desc_matcher_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [DIST_W-1:0] TH   = DIST_W'(DIST_TH);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ISSUE  = ST_ISSUE;
  localparam logic [1:0] DRAIN  = ST_DRAIN;
  localparam logic [1:0] REPORT = ST_REPORT;

  logic [1:0]        state, state_nxt;
  logic [CW-1:0]     count, ret_cnt, ret_cnt_nxt;
  logic [IW-1:0]     issue_idx;
  logic [DESC_W-1:0] src_q, rd_desc;
  logic [DIST_W-1:0] best, best_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              found_nxt;
  logic              accept, ret, last_issue, ret_done, wr_ok;
  logic              match_valid, match_found;
  logic [IW-1:0]     match_idx;
  logic [DIST_W-1:0] match_dist;
`ifdef MATCH_RATIO_TEST_EN
  logic [DIST_W-1:0] second, second_nxt;
`endif

  assign accept      = (state == IDLE) && bus.i_query_valid;
  assign ret         = (state != IDLE) && bus.i_ham_valid;
  assign ret_cnt_nxt = ret_cnt + CW'(ret);
  assign ret_done    = (ret_cnt_nxt == count);
  assign last_issue  = (state == ISSUE) && ({1'b0, issue_idx} == count - CW'(1));
  assign wr_ok       = (state == IDLE) && !bus.i_dst_clear && bus.i_dst_wr && (count != FULL);

  desc_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (i_clk),
    .we    (wr_ok),
    .waddr (count[IW-1:0]),
    .wdata (bus.i_dst_desc),
    .raddr (issue_idx),
    .rdata (rd_desc)
  );

  // Accept preloads the trackers so an empty store reports DIST_MAX straight away.
  always_comb begin
    best_nxt = best;
    idx_nxt  = idx;
`ifdef MATCH_RATIO_TEST_EN
    second_nxt = second;
`endif
    if (accept) begin
      best_nxt = DIST_MAX;
      idx_nxt  = '0;
`ifdef MATCH_RATIO_TEST_EN
      second_nxt = DIST_MAX;
`endif
    end else if (ret && (bus.i_ham_dist < best)) begin
      best_nxt = bus.i_ham_dist;
      idx_nxt  = ret_cnt[IW-1:0];
`ifdef MATCH_RATIO_TEST_EN
      second_nxt = best;
    end else if (ret && (bus.i_ham_dist < second)) begin
      second_nxt = bus.i_ham_dist;
`endif
    end
  end

  always_comb begin
    found_nxt = (best_nxt <= TH);
`ifdef MATCH_RATIO_TEST_EN
    found_nxt = found_nxt && ({best_nxt, 2'b00} < (11'(second_nxt) * 11'd3));
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (count == '0) ? REPORT : ISSUE;
      ISSUE:   if (last_issue) state_nxt = ret_done ? REPORT : DRAIN;
      DRAIN:   if (ret_done) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= '0;
      issue_idx   <= '0;
      ret_cnt     <= '0;
      src_q       <= '0;
      best        <= DIST_MAX;
      idx         <= '0;
      match_valid <= 1'b0;
      match_found <= 1'b0;
      match_idx   <= '0;
      match_dist  <= '0;
`ifdef MATCH_RATIO_TEST_EN
      second      <= DIST_MAX;
`endif
    end else begin
      state       <= state_nxt;
      best        <= best_nxt;
      idx         <= idx_nxt;
`ifdef MATCH_RATIO_TEST_EN
      second      <= second_nxt;
`endif
      match_valid <= (state_nxt == REPORT);
      if (state_nxt == REPORT) begin
        match_found <= found_nxt;
        match_idx   <= idx_nxt;
        match_dist  <= best_nxt;
      end
      if (state == IDLE) begin
        if (bus.i_dst_clear) count <= '0;
        else if (wr_ok)      count <= count + CW'(1);
      end
      if (accept) begin
        src_q     <= bus.i_query_desc;
        issue_idx <= '0;
        ret_cnt   <= '0;
      end else begin
        ret_cnt <= ret_cnt_nxt;
        if (state == ISSUE) issue_idx <= issue_idx + IW'(1);
      end
    end
  end

  assign bus.o_dst_ready   = (state == IDLE);
  assign bus.o_query_ready = (state == IDLE);
  assign bus.o_dst_count   = count;
  assign bus.o_ham_valid   = (state == ISSUE);
  assign bus.o_src_desc    = src_q;
  assign bus.o_dst_desc    = (state == ISSUE) ? rd_desc : '0;
  assign bus.o_match_valid = match_valid;
  assign bus.o_match_found = match_found;
  assign bus.o_match_idx   = match_idx;
  assign bus.o_match_dist  = match_dist;
endmodule

// File: tb/tb_desc_matcher.sv
// Directed bench for desc_matcher with a 2-cycle Hamming distance unit model beside it.
module tb_desc_matcher;
  localparam int DEPTH = 64;
  localparam logic [255:0] QRY = {8{32'hA5C3_0F96}};

  logic clk, rst_n;
  int n_chk = 0, n_err = 0;

  desc_matcher_if #(.DEPTH(DEPTH)) bus ();

  desc_matcher #(.DEPTH(DEPTH), .DIST_TH(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two-stage distance unit sharing the reset
  logic       v1;
  logic [8:0] d1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0; d1 <= '0; bus.i_ham_valid <= 1'b0; bus.i_ham_dist <= '0;
    end else begin
      v1 <= bus.o_ham_valid;
      d1 <= 9'($countones(bus.o_src_desc ^ bus.o_dst_desc));
      bus.i_ham_valid <= v1;
      bus.i_ham_dist  <= d1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int k);
    logic [255:0] m = '0;
    for (int i = 0; i < k; i++) m[i] = 1'b1;
    return QRY ^ m;
  endfunction

  task automatic wr(input logic [255:0] d);
    @(negedge clk); bus.i_dst_wr = 1'b1; bus.i_dst_desc = d;
    @(negedge clk); bus.i_dst_wr = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk); bus.i_dst_clear = 1'b1;
    @(negedge clk); bus.i_dst_clear = 1'b0;
  endtask

  task automatic run_query(output int cyc, output int pairs);
    cyc = 0; pairs = 0;
    @(negedge clk); bus.i_query_valid = 1'b1; bus.i_query_desc = QRY;
    @(posedge clk); #1 bus.i_query_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.o_ham_valid) pairs++;
      if (bus.o_match_valid) begin cyc = c; break; end
    end
  endtask

  task automatic expect_match(input string tag, input int cyc_e, input int found_e,
                              input int idx_e, input int dist_e);
    int cyc, pairs;
    run_query(cyc, pairs);
    check({tag, "_cyc"},   32'(cyc), 32'(cyc_e));
    check({tag, "_found"}, 32'(bus.o_match_found), 32'(found_e));
    check({tag, "_idx"},   32'(bus.o_match_idx), 32'(idx_e));
    check({tag, "_dist"},  32'(bus.o_match_dist), 32'(dist_e));
    if (cyc_e > 1) check({tag, "_pairs"}, 32'(pairs), 32'(cyc_e - 3));
  endtask

  initial begin
    int strobes, cyc, pairs;
    rst_n = 1'b0;
    bus.i_dst_wr = 1'b0; bus.i_dst_desc = '0; bus.i_dst_clear = 1'b0;
    bus.i_query_valid = 1'b0; bus.i_query_desc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_mvalid", 32'(bus.o_match_valid), 0);
    check("rst_found",  32'(bus.o_match_found), 0);
    check("rst_idx",    32'(bus.o_match_idx), 0);
    check("rst_dist",   32'(bus.o_match_dist), 0);
    check("rst_hvalid", 32'(bus.o_ham_valid), 0);
    check("rst_src",    32'(bus.o_src_desc != '0), 0);
    check("rst_dst",    32'(bus.o_dst_desc != '0), 0);
    check("rst_count",  32'(bus.o_dst_count), 0);
    check("rst_qready", 32'(bus.o_query_ready), 1);
    check("rst_dready", 32'(bus.o_dst_ready), 1);

    expect_match("empty", 1, 0, 0, 9'h1FF);

    wr(mk(10)); wr(mk(3)); wr(mk(50)); wr(mk(3));
    @(negedge clk);
    check("load4_count", 32'(bus.o_dst_count), 4);
`ifdef MATCH_RATIO_TEST_EN
    expect_match("q4", 7, 0, 1, 3);
`else
    expect_match("q4", 7, 1, 1, 3);
`endif
    @(negedge clk);
    check("q4_strobe_drop", 32'(bus.o_match_valid), 0);
    check("q4_ready_back",  32'(bus.o_query_ready), 1);
    check("q4_dist_held",   32'(bus.o_match_dist), 3);

    clr(); wr(mk(65)); wr(mk(100));
    expect_match("over_th", 5, 0, 0, 65);

    clr(); wr(mk(64));
    expect_match("at_th", 4, 1, 0, 64);

    clr(); wr(mk(30)); wr(mk(35));
`ifdef MATCH_RATIO_TEST_EN
    expect_match("ratio_close", 5, 0, 0, 30);
`else
    expect_match("ratio_close", 5, 1, 0, 30);
`endif
    clr(); wr(mk(20)); wr(mk(40));
    expect_match("ratio_far", 5, 1, 0, 20);

    clr();
    for (int i = 0; i <= DEPTH; i++) wr(mk(i < DEPTH ? 100 - i : 1));
    @(negedge clk);
    check("full_count", 32'(bus.o_dst_count), DEPTH);
`ifdef MATCH_RATIO_TEST_EN
    expect_match("full", DEPTH + 3, 0, DEPTH - 1, 37);
`else
    expect_match("full", DEPTH + 3, 1, DEPTH - 1, 37);
`endif

    clr(); wr(mk(5)); wr(mk(6)); wr(mk(7));
    @(negedge clk); bus.i_query_valid = 1'b1; bus.i_query_desc = QRY;
    @(posedge clk); #1 bus.i_query_valid = 1'b0;
    @(negedge clk);
    check("abort_issuing", 32'(bus.o_ham_valid), 1);
    bus.i_dst_wr = 1'b1; bus.i_dst_desc = mk(1);
    @(negedge clk);
    bus.i_dst_wr = 1'b0;
    check("busy_wr_ignored", 32'(bus.o_dst_count), 3);
    rst_n = 1'b0;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.o_match_valid) strobes++;
    end
    check("abort_no_strobe", 32'(strobes), 0);
    check("abort_count",     32'(bus.o_dst_count), 0);
    check("abort_qready",    32'(bus.o_query_ready), 1);
    check("abort_dready",    32'(bus.o_dst_ready), 1);
    run_query(cyc, pairs);
    check("post_abort_cyc",   32'(cyc), 1);
    check("post_abort_found", 32'(bus.o_match_found), 0);
    check("post_abort_dist",  32'(bus.o_match_dist), 32'h1FF);
    check("post_abort_pairs", 32'(pairs), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/desc_matcher.md
# desc_matcher

Brute-force descriptor matcher that drives the two-stage Hamming distance unit from the initiator side. It stores up to DEPTH reference (destination) descriptors. For each query (source) descriptor it issues one descriptor pair per cycle to the distance unit, consumes the returned distances, and reports the best match index and distance. It sits between the feature/descriptor front-end and the pose-estimation back-end of the visual odometry pipeline.

## Interface
- DEPTH, 64, maximum stored destination descriptors (power of two)
- DIST_TH, 64, largest distance accepted as a match
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_dst_wr  in  1  write one destination descriptor
- i_dst_desc  in  256  destination descriptor
- i_dst_clear  in  1  empty the store
- o_dst_ready  out  1  store accepts writes/clear (IDLE only)
- o_dst_count  out  $clog2(DEPTH)+1  descriptors stored
- i_query_valid  in  1  query descriptor present
- i_query_desc  in  256  query descriptor
- o_query_ready  out  1  query accepted this cycle when valid
- o_ham_valid  out  1  pair valid to distance unit
- o_src_desc  out  256  query descriptor to distance unit
- o_dst_desc  out  256  stored descriptor to distance unit
- i_ham_dist  in  9  returned distance
- i_ham_valid  in  1  returned distance valid
- o_match_valid  out  1  one-cycle result strobe
- o_match_found  out  1  best match passes acceptance
- o_match_idx  out  $clog2(DEPTH)  index of best match
- o_match_dist  out  9  best distance

## Operation
- FSM states: IDLE, ISSUE, DRAIN, REPORT.
- IDLE:
  - o_query_ready=1 and o_dst_ready=1.
  - i_dst_clear has priority over i_dst_wr and sets count to 0.
  - A write when count==DEPTH is dropped and count is unchanged.
  - Query accept (valid&ready) latches i_query_desc, zeroes issue and return counters, and sets best=second=9'h1FF and idx=0.
  - Next state is ISSUE, or REPORT if count==0.
- ISSUE:
  - One pair per cycle: o_ham_valid=1, o_dst_desc=store[issue_idx].
  - issue_idx runs 0..count-1, then the FSM moves to DRAIN.
  - o_src_desc holds the latched query for the whole query.
- DRAIN: wait until returned count equals count, then go to REPORT.
- Result handling, in any state other than IDLE:
  - Results are consumed on i_ham_valid, in issue order; the return counter gives the index.
  - If d<best: second=best, best=d, idx=ret_idx.
  - Else if d<second: second=d.
  - Ties keep the lower index.
- REPORT:
  - o_match_valid=1 for one cycle; next state is IDLE.
  - found = (best<=DIST_TH), plus the ratio test when it is compiled in.
- i_ham_valid in IDLE is ignored.
- Writes and clear outside IDLE are ignored.
- Changing count mid-query is impossible.

## Timing
- Reset values: o_match_valid=0, o_match_found=0, o_match_idx=0, o_match_dist=0, o_ham_valid=0, o_src_desc=0, o_dst_desc=0, o_dst_count=0.
- Reset values, continued: o_query_ready=1, o_dst_ready=1; FSM in IDLE.
- Storage contents are not reset.
- Query accepted at edge 0: pairs issue in cycles 1..N.
- With the 2-cycle distance unit the last result arrives in cycle N+2.
- o_match_valid is asserted in cycle N+3; ready returns in cycle N+4.
- The latency count never relies on the distance unit's depth. Completion is decided by counting returns only.
- count==0: o_match_valid in cycle 1 with found=0, dist=0x1FF, idx=0.
- Reset mid-query aborts immediately with no strobe. The distance unit shares the reset, so no stale returns arrive.
- Match outputs are registered and held until the next REPORT.

## Configuration
- MATCH_RATIO_TEST_EN defined:
  - found additionally requires 4*best < 3*second, computed at 11 bits.
  - A single stored descriptor leaves second=0x1FF, so the ratio test passes.
- MATCH_RATIO_TEST_EN undefined: the second-best tracker is not built, and found = best<=DIST_TH only.

## Structure
- Package vo_match_pkg: DESC_W=256, DIST_W=9, DIST_MAX=9'h1FF, and the FSM state enum.
- Sub-module desc_buffer: DEPTH×256 register file with synchronous write and combinational read by index.
- The distance unit is instantiated beside this block, not inside it.

## Test plan
- Load 4 descriptors with distances 10, 3, 50, 3 to the query -> idx=1, dist=3, found=1; strobe at cycle 7 after accept.
- Query with count==0 -> strobe at cycle 1: found=0, dist=0x1FF, idx=0.
- Load DEPTH+1 descriptors -> count==DEPTH and the extra write is dropped. A query issues exactly DEPTH pairs.
- Best distance 65 with DIST_TH=64 -> found=0, dist=65.
- With MATCH_RATIO_TEST_EN, distances 30 and 35 -> found=0. Distances 20 and 40 -> found=1, dist=20.
- Assert reset during ISSUE -> no strobe, count=0, ready=1. A subsequent query with count 0 behaves as in the empty-store case.
